// File: rtl/video_timing_detector.sv
// video_timing_detector: recovers pixel coordinates from DE/sync and locks onto stable frame timing.
module video_timing_detector #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk_pixel,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             data_enable,
  output logic             de_out,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             frame_start,
  output logic             line_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             timing_error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  state_t state, nxt;
  logic hs_r, vs_r, de_r, armed;
  logic hs_rise, vs_rise, de_rise, de_fall, fs, line_bad, frame_bad, cand_match, to_hit;
  logic enter, lose, cap;
  logic [CNT_W-1:0] h_cnt, h_meas, w_cnt, w_meas, v_cnt, va_cnt, c_ht, c_ha, c_vt, c_va;
  logic [TW-1:0] to_cnt;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != CMAX) ? c + CNT_W'(1) : c;
  endfunction
  assign hs_rise = hsync & ~hs_r;
  assign vs_rise = vsync & ~vs_r;
  assign de_rise = data_enable & ~de_r;
  assign de_fall = ~data_enable & de_r;
  // the first line after a vsync rise (even in the same cycle) is line 0 of the new frame
  assign fs = de_rise & (armed | vs_rise);
  assign de_out = de_r;
  assign to_hit = !vs_rise && to_cnt == TW'(TIMEOUT - 1);
  // the line that spans vertical blanking has no meaningful spacing, so it is never checked
  assign line_bad = de_rise && ((!fs && h_cnt != h_total) || w_meas != h_active);
  assign frame_bad = v_cnt != v_total || va_cnt != v_active;
  assign cand_match = {h_meas, w_meas, v_cnt, va_cnt} == {c_ht, c_ha, c_vt, c_va};
  always_ff @(posedge clk_pixel) state <= rst ? SEARCH : nxt;
  always_comb begin
    nxt = state;
    if (vs_rise) nxt = state == SEARCH ? MEASURE : state == MEASURE ? VERIFY :
                       state == VERIFY ? (cand_match ? LOCKED : VERIFY) : (frame_bad ? MEASURE : LOCKED);
    if (state == LOCKED && line_bad) nxt = MEASURE;
    if (to_hit) nxt = SEARCH;
  end
  always_comb begin
    enter = state == VERIFY && nxt == LOCKED;
    lose = state == LOCKED && nxt != LOCKED;
    cap = vs_rise && (state == MEASURE || state == VERIFY);
  end
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      {hs_r, vs_r, de_r, armed, frame_start, line_start, locked, timing_error} <= '0;
      {pixel_x, pixel_y} <= '0;
      {h_cnt, h_meas, w_cnt, w_meas, v_cnt, va_cnt} <= '0;
      {c_ht, c_ha, c_vt, c_va, h_total, h_active, v_total, v_active} <= '0;
      to_cnt <= '0;
    end else begin
      hs_r <= hsync;
      vs_r <= vsync;
      de_r <= data_enable;
      armed <= vs_rise ? !de_rise : armed & !de_rise;
      pixel_x <= de_rise ? '0 : (data_enable && pixel_x != 10'd1023) ? pixel_x + 10'd1 : pixel_x;
      pixel_y <= fs ? '0 : (de_rise && pixel_y != 10'd1023) ? pixel_y + 10'd1 : pixel_y;
      frame_start <= fs;
      line_start <= de_rise;
      h_cnt <= de_rise ? CNT_W'(1) : sat(h_cnt, 1'b1);
      w_cnt <= de_rise ? CNT_W'(1) : sat(w_cnt, data_enable & de_r);
      if (de_rise && !fs) h_meas <= h_cnt;
      if (de_fall) w_meas <= w_cnt;
      v_cnt <= vs_rise ? CNT_W'(hs_rise) : sat(v_cnt, hs_rise);
      va_cnt <= vs_rise ? CNT_W'(de_rise) : sat(va_cnt, de_rise);
      to_cnt <= (vs_rise || to_hit) ? '0 : to_cnt + TW'(1);
      if (cap) {c_ht, c_ha, c_vt, c_va} <= {h_meas, w_meas, v_cnt, va_cnt};
      if (enter) {h_total, h_active, v_total, v_active} <= {c_ht, c_ha, c_vt, c_va};
      locked <= nxt == LOCKED;
      timing_error <= lose;
    end
  end
endmodule
